rx_frame_fifo: RTL and testbench
================================

Name: rx_frame_fifo

Overview:
Store-and-forward byte FIFO placed directly downstream of the MII MAC receiver. It accepts the MAC's byte stream (wr_en/data) together with the end-of-frame verdict (frame_valid / frame_err). Only frames that end with a good verdict are committed. Bad or overflowed frames are rolled back. Committed frames are presented to the UDP parser on a valid/ready byte stream with a last-byte marker.

Parameters:
DEPTH, 2048, data buffer depth in bytes; power of 2, at least 64.
MAX_FRAMES, 16, depth of the committed-frame length queue; power of 2.
DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
rx_clk  in  1  single clock for write and read sides.
rst  in  1  asynchronous, active-high reset.
wr_data  in  8  byte from MAC.
wr_en  in  1  byte strobe from MAC.
frame_valid  in  1  frame ended with good FCS; a coincident wr_en byte is the frame's last byte.
frame_err  in  1  frame bad (MAC or CRC); a coincident wr_en byte is discarded.
m_data  out  8  output byte.
m_valid  out  1  m_data holds a byte of a committed frame.
m_last  out  1  qualifies m_data as the final byte of its frame.
m_ready  in  1  downstream accepts the byte when m_valid && m_ready.
frames_stored  out  $clog2(MAX_FRAMES)+1  number of committed frames not yet fully read.
drop_pulse  out  1  one-cycle pulse per dropped frame.
drop_cnt  out  DROP_CNT_W  count of dropped frames; saturates at all-ones.

Behaviour:
- Reset: all pointers and counters are 0. m_valid=0, m_last=0, m_data=0, frames_stored=0, drop_pulse=0, drop_cnt=0. Any partial frame is lost. Reset mid-read abandons the current frame.
- Pointers: $clog2(DEPTH)+1 bits, wrap naturally.
  - wr_ptr is speculative.
  - commit_ptr marks the end of the last good frame.
  - rd_ptr is the read position.
  - Space is full when wr_ptr - rd_ptr == DEPTH.
- Write state machine, states IDLE, RECV, OVF.
  - IDLE: wr_en writes the byte, sets frame length to 1, and moves to RECV.
  - RECV: each wr_en writes one byte and increments the length.
  - RECV to OVF: a wr_en while space is full moves to OVF; that byte and all later bytes are ignored.
  - End of frame (RECV): frame_valid alone commits the frame, including a coincident byte.
  - Commit action: commit_ptr <= wr_ptr (post-write), and the length is pushed to the length queue.
  - frame_err in RECV: rolls wr_ptr back to commit_ptr and asserts drop_pulse on the next cycle.
  - frame_err priority: if frame_valid and frame_err are both high, frame_err wins.
  - End of frame (OVF): frame_valid or frame_err rolls back and asserts drop_pulse. Returns to IDLE.
  - Length queue full: a commit with the length queue full becomes a rollback plus drop_pulse.
  - Empty frames: frame_valid or frame_err in IDLE with no byte is ignored; no drop is counted.
  - Frame-start collision: frame_err/frame_valid arriving in IDLE together with wr_en ends a 1-byte frame under the same rules.
- drop_cnt increments on each drop_pulse cycle.
- Read side: first-word-fall-through, using synchronous memory reads with a registered output stage.
  - Latency: with the output empty, m_valid rises exactly 2 cycles after the commit edge.
  - Throughput: 1 byte/cycle while m_ready=1.
  - Hold: while m_valid && !m_ready, m_data, m_last and m_valid hold stable.
  - A down-counter loaded from the length queue head drives m_last.
  - On the handshake of the m_last byte, the length entry is popped.
  - Back-to-back frames: the next frame's first byte follows with no bubble if already committed.
- Uncommitted bytes are never readable: reads stop at commit_ptr.
- frames_stored is incremented at commit and decremented at the m_last handshake. If both happen in the same cycle, it is unchanged.
- Simultaneous write-side rollback and read are independent. A rollback never moves rd_ptr or commit_ptr.

Test Plan:
- Good frame: 60-byte frame with frame_valid on the 60th wr_en, m_ready=1 → m_valid rises 2 cycles later. 60 bytes are output in order; m_last is set on byte 60 only; frames_stored goes 1 then 0; drop_cnt=0.
- Bad frame between good: good A (20 B), bad B (30 B, frame_err with the last byte), good C (25 B) → output is A then C only (45 bytes, two m_last). drop_pulse fires once; drop_cnt=1.
- Backpressure: 3 committed 10-byte frames, m_ready toggled 1/0 pseudo-randomly → every byte is delivered exactly once. Outputs hold stable during stalls; m_last falls on bytes 10, 20 and 30.
- Overflow: DEPTH=64, m_ready=0, send a 70-byte frame with frame_valid → frame dropped, drop_cnt=1, frames_stored=0. A following 40-byte frame commits and reads out correctly.
- Length-queue full: MAX_FRAMES=4, m_ready=0, send 5 one-byte good frames → frames_stored=4, drop_cnt=1. Releasing m_ready yields 4 frames.
- Reset mid-frame: assert rst after 15 bytes of a frame and while a read is in progress → all outputs are 0 next cycle. A subsequent 8-byte frame is received intact.

Source files
------------

// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: store-and-forward receive byte FIFO.
// Bytes from the MAC are written speculatively. A frame becomes readable only
// once it ends with a good verdict. Bad, overflowed or unqueueable frames are
// rolled back and counted as drops. The read side is first-word-fall-through:
// a synchronous memory read stage feeds a registered output stage.
module rx_frame_fifo #(
    parameter int DEPTH      = 2048,
    parameter int MAX_FRAMES = 16,
    parameter int DROP_CNT_W = 16
) (
    input  logic                        rx_clk,
    input  logic                        rst,
    input  logic [7:0]                  wr_data,
    input  logic                        wr_en,
    input  logic                        frame_valid,
    input  logic                        frame_err,
    output logic [7:0]                  m_data,
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic [$clog2(MAX_FRAMES):0] frames_stored,
    output logic                        drop_pulse,
    output logic [DROP_CNT_W-1:0]       drop_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int LW  = AW + 1;
    localparam int QW  = $clog2(MAX_FRAMES);
    localparam int QPW = QW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        OVF  = 2'd2
    } wr_state_t;

    wr_state_t       state;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   commit_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   frame_len;
    logic [LW-1:0]   len_q [MAX_FRAMES];
    logic [QPW-1:0]  lq_wr;
    logic [QPW-1:0]  lq_rd;

    logic            s1_valid;
    logic [7:0]      s1_data;
    logic [LW-1:0]   rem_cnt;

    logic            space_full;
    logic            lq_full;
    logic            mem_we;
    logic [PW-1:0]   wr_next;
    logic [LW-1:0]   len_next;

    logic            out_adv;
    logic            s1_move;
    logic            rd_issue;
    logic [QW-1:0]   head_idx;
    logic [LW-1:0]   head_len;
    logic            next_last;
    logic [LW-1:0]   rem_next;

    // Space is measured against the fetch pointer: a byte already pulled into
    // the read pipeline no longer needs its memory slot.
    assign space_full    = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign frames_stored = lq_wr - lq_rd;
    assign lq_full       = frames_stored == QPW'(MAX_FRAMES);
    assign mem_we        = wr_en && !frame_err && !space_full && (state != OVF);
    assign wr_next       = wr_ptr + PW'(wr_en);
    assign len_next      = frame_len + LW'(wr_en);

    // Read pipeline control and frame-boundary tracking for the byte that is
    // about to enter the output register.
    always_comb begin
        out_adv   = !m_valid || m_ready;
        s1_move   = s1_valid && out_adv;
        rd_issue  = (rd_ptr != commit_ptr) && (!s1_valid || s1_move);
        // If the output holds a last byte that is leaving now, the entering
        // byte belongs to the frame after the queue head.
        head_idx  = lq_rd[QW-1:0] + QW'(m_valid && m_last);
        head_len  = len_q[head_idx];
        next_last = 1'b0;
        rem_next  = rem_cnt;
        if (rem_cnt == '0) begin
            next_last = (head_len == LW'(1));
            rem_next  = head_len - LW'(1);
        end else begin
            next_last = (rem_cnt == LW'(1));
            rem_next  = rem_cnt - LW'(1);
        end
    end

    // Byte storage: one write port, one synchronous read port.
    always_ff @(posedge rx_clk) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= wr_data;
        if (rd_issue) s1_data <= mem[rd_ptr[AW-1:0]];
    end

    // Write-side frame FSM: speculative writes, commit, rollback and drop count.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            frame_len  <= '0;
            lq_wr      <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
            for (int i = 0; i < MAX_FRAMES; i++) len_q[i] <= '0;
        end else begin
            drop_pulse <= 1'b0;
            if (drop_pulse && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        if (frame_err) begin
                            drop_pulse <= 1'b1;
                        end else if (space_full) begin
                            if (frame_valid) drop_pulse <= 1'b1;
                            else             state      <= OVF;
                        end else if (frame_valid) begin
                            if (lq_full) begin
                                drop_pulse <= 1'b1;
                            end else begin
                                wr_ptr                 <= wr_ptr + PW'(1);
                                commit_ptr             <= wr_ptr + PW'(1);
                                len_q[lq_wr[QW-1:0]]   <= LW'(1);
                                lq_wr                  <= lq_wr + QPW'(1);
                            end
                        end else begin
                            wr_ptr    <= wr_ptr + PW'(1);
                            frame_len <= LW'(1);
                            state     <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (frame_err) begin
                        wr_ptr     <= commit_ptr;
                        drop_pulse <= 1'b1;
                        state      <= IDLE;
                    end else if (wr_en && space_full) begin
                        if (frame_valid) begin
                            wr_ptr     <= commit_ptr;
                            drop_pulse <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= OVF;
                        end
                    end else if (frame_valid) begin
                        if (lq_full) begin
                            wr_ptr     <= commit_ptr;
                            drop_pulse <= 1'b1;
                        end else begin
                            wr_ptr               <= wr_next;
                            commit_ptr           <= wr_next;
                            len_q[lq_wr[QW-1:0]] <= len_next;
                            lq_wr                <= lq_wr + QPW'(1);
                        end
                        state <= IDLE;
                    end else if (wr_en) begin
                        wr_ptr    <= wr_ptr + PW'(1);
                        frame_len <= frame_len + LW'(1);
                    end
                end
                OVF: begin
                    if (frame_valid || frame_err) begin
                        wr_ptr     <= commit_ptr;
                        drop_pulse <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read side: fetch committed bytes, load the output register, mark and pop frame ends.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            s1_valid <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            rem_cnt  <= '0;
            lq_rd    <= '0;
        end else begin
            if (rd_issue) rd_ptr <= rd_ptr + PW'(1);
            if (rd_issue)     s1_valid <= 1'b1;
            else if (s1_move) s1_valid <= 1'b0;
            if (out_adv) begin
                m_valid <= s1_valid;
                if (s1_valid) begin
                    m_data  <= s1_data;
                    m_last  <= next_last;
                    rem_cnt <= rem_next;
                end else begin
                    m_last <= 1'b0;
                end
            end
            if (m_valid && m_ready && m_last) lq_rd <= lq_rd + QPW'(1);
        end
    end

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Self-checking bench for rx_frame_fifo. A scoreboard of expected bytes (with
// frame-end marks) is filled from the frames the bench decides should commit,
// and a frame counter / drop counter model tracks the status outputs.
module tb_rx_frame_fifo;

    localparam int DEPTH      = 64;
    localparam int MAX_FRAMES = 4;
    localparam int DROP_CNT_W = 16;

    logic                        rx_clk = 1'b0;
    logic                        rst;
    logic [7:0]                  wr_data;
    logic                        wr_en;
    logic                        frame_valid;
    logic                        frame_err;
    logic [7:0]                  m_data;
    logic                        m_valid;
    logic                        m_last;
    logic                        m_ready;
    logic [$clog2(MAX_FRAMES):0] frames_stored;
    logic                        drop_pulse;
    logic [DROP_CNT_W-1:0]       drop_cnt;

    rx_frame_fifo #(.DEPTH(DEPTH), .MAX_FRAMES(MAX_FRAMES), .DROP_CNT_W(DROP_CNT_W)) dut (
        .rx_clk(rx_clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .frames_stored(frames_stored), .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct { logic [7:0] d; logic last; } beat_t;
    // kind: 0 good on last byte, 1 good one cycle after, 2 err on last byte,
    //       3 err one cycle after, 4 valid+err on last byte, 5 left open
    typedef struct { int len; int kind; bit gaps; bit commit; int drops; int bytes; } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[12];
    int checks = 0, failures = 0;
    int model_stored = 0, model_drops = 0;
    int obs_drops = 0, obs_frames = 0, obs_bytes = 0;
    bit mon_en = 1'b0;
    int ready_mode = 1;
    bit stall_prev = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge rx_clk);
            #1;
        end
    endtask

    // Downstream ready generator.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge rx_clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: scoreboard, stall stability, drop pulse counting.
    always @(posedge rx_clk) begin
        if (rst || !mon_en) begin
            stall_prev = 1'b0;
        end else begin
            if (drop_pulse) obs_drops++;
            if (stall_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got data %0d with nothing expected (t=%0t)", m_data, $time);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.d);
                    check("m_last", m_last, e.last);
                    obs_bytes++;
                    if (e.last) begin
                        obs_frames++;
                        model_stored--;
                    end
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    always @(negedge rx_clk) begin
        if (!rst && mon_en) check("frames_stored", frames_stored, model_stored);
    end

    task automatic send_frame(input int len, input int kind, input bit gaps, input bit expect_commit);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wr_en = 1'b0;
                tick();
            end
            wr_en   = 1'b1;
            wr_data = 8'($urandom);
            if (i == len - 1) begin
                frame_valid = (kind == 0 || kind == 4);
                frame_err   = (kind == 2 || kind == 4);
            end
            if (expect_commit) begin
                b.d    = wr_data;
                b.last = (i == len - 1);
                exp_q.push_back(b);
            end
            tick();
        end
        wr_en = 1'b0; frame_valid = 1'b0; frame_err = 1'b0;
        if (kind == 1 || kind == 3) begin
            frame_valid = (kind == 1);
            frame_err   = (kind == 3);
            tick();
            frame_valid = 1'b0; frame_err = 1'b0;
        end
        if (expect_commit) model_stored++;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", m_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_frames_stored"}, frames_stored, 0);
        check({tag, "_drop_pulse"}, drop_pulse, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    initial begin
        int b0, f0, n, r, len, kind;
        bit good;

        vecs[0]  = '{20, 0, 1'b0, 1'b1, 0, 20};
        vecs[1]  = '{30, 2, 1'b0, 1'b0, 1, 0};
        vecs[2]  = '{25, 0, 1'b0, 1'b1, 0, 25};
        vecs[3]  = '{12, 1, 1'b1, 1'b1, 0, 12};
        vecs[4]  = '{12, 3, 1'b1, 1'b0, 1, 0};
        vecs[5]  = '{10, 4, 1'b0, 1'b0, 1, 0};
        vecs[6]  = '{1,  0, 1'b0, 1'b1, 0, 1};
        vecs[7]  = '{1,  2, 1'b0, 1'b0, 1, 0};
        vecs[8]  = '{1,  4, 1'b0, 1'b0, 1, 0};
        vecs[9]  = '{0,  1, 1'b0, 1'b0, 0, 0};
        vecs[10] = '{0,  3, 1'b0, 1'b0, 0, 0};
        vecs[11] = '{64, 0, 1'b0, 1'b1, 0, 64};

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; frame_valid = 1'b0; frame_err = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        ready_mode = 1;
        tick(3);

        // 60-byte good frame, first-byte latency and frame count
        send_frame(60, 0, 1'b0, 1'b1);
        check("lat_commit_edge", m_valid, 0);
        check("stored_after_commit", frames_stored, 1);
        tick();
        check("lat_plus1", m_valid, 0);
        tick();
        check("lat_plus2", m_valid, 1);
        wait_drain(200);
        check("good_drop_cnt", drop_cnt, 0);

        // Directed frame table
        foreach (vecs[i]) begin
            b0 = obs_bytes;
            send_frame(vecs[i].len, vecs[i].kind, vecs[i].gaps, vecs[i].commit);
            model_drops += vecs[i].drops;
            tick(3);
            wait_drain(300);
            check("vec_bytes", obs_bytes - b0, vecs[i].bytes);
            check("vec_drop_cnt", drop_cnt, model_drops);
            check("vec_drop_pulses", obs_drops, model_drops);
        end

        // Overflow: 70 bytes into a 64-byte buffer with no reads
        ready_mode = 0;
        tick(3);
        send_frame(70, 0, 1'b0, 1'b0);
        model_drops++;
        tick(4);
        check("ovf_drop_cnt", drop_cnt, model_drops);
        check("ovf_stored", frames_stored, 0);
        check("ovf_no_valid", m_valid, 0);
        send_frame(40, 0, 1'b0, 1'b1);
        tick(4);
        check("ovf_next_valid", m_valid, 1);
        ready_mode = 1;
        b0 = obs_bytes;
        wait_drain(300);
        check("ovf_next_bytes", obs_bytes - b0, 40);

        // Backpressure: three committed 10-byte frames, random ready
        ready_mode = 0;
        tick(2);
        for (int i = 0; i < 3; i++) send_frame(10, 0, 1'b0, 1'b1);
        b0 = obs_bytes; f0 = obs_frames;
        ready_mode = 2;
        wait_drain(600);
        ready_mode = 1;
        check("bp_bytes", obs_bytes - b0, 30);
        check("bp_frames", obs_frames - f0, 3);

        // Length queue full: five one-byte frames, no reads
        ready_mode = 0;
        tick(2);
        for (int i = 0; i < 5; i++) send_frame(1, 0, 1'b0, i < 4);
        model_drops++;
        tick(3);
        check("lq_stored", frames_stored, 4);
        check("lq_drop_cnt", drop_cnt, model_drops);
        f0 = obs_frames;
        ready_mode = 1;
        wait_drain(200);
        check("lq_frames_out", obs_frames - f0, 4);

        // Reset while a frame is being received and another is being read
        ready_mode = 1;
        tick(2);
        send_frame(30, 0, 1'b0, 1'b1);
        send_frame(15, 5, 1'b0, 1'b0);
        check("read_in_progress", m_valid, 1);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #2;
        check_reset_outputs("async_rst");
        exp_q.delete();
        model_stored = 0; model_drops = 0; obs_drops = 0;
        tick();
        check_reset_outputs("rst_next");
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick(2);
        b0 = obs_bytes;
        send_frame(8, 0, 1'b0, 1'b1);
        wait_drain(100);
        check("post_rst_bytes", obs_bytes - b0, 8);

        // Randomized traffic against the scoreboard
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            n = 0;
            while ((model_stored > 2 || exp_q.size() > 24) && n < 2000) begin
                tick();
                n++;
            end
            check("rand_wait_room", (model_stored > 2 || exp_q.size() > 24), 0);
            len = $urandom_range(1, 20);
            r = $urandom_range(0, 9);
            case (r)
                5:       kind = 1;
                6:       kind = 2;
                7:       kind = 3;
                8:       kind = 4;
                default: kind = 0;
            endcase
            good = (kind <= 1);
            send_frame(len, kind, 1'($urandom_range(0, 1)), good);
            if (!good) model_drops++;
            tick($urandom_range(0, 3));
        end
        ready_mode = 1;
        tick(3);
        wait_drain(1000);
        check("rand_drop_cnt", drop_cnt, model_drops);
        check("rand_drop_pulses", obs_drops, model_drops);
        check("rand_stored_end", frames_stored, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
